// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage owning the PC, one outstanding imem read, registered output slot
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   i_stall           decode cannot accept; output slot holds
//   i_redirect        control transfer; flushes slot and any in-flight fetch
//   i_target          redirect PC (low two bits ignored)
//   o_imem_req        one-cycle read request
//   o_imem_addr       read address (current PC)
//   i_imem_rvalid     read data valid
//   i_imem_rdata      instruction word
//   o_valid           output slot holds a live instruction
//   o_instruct, o_pc  instruction and its PC for decode
module if_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_instruct,
    output logic [31:0] o_pc
);
    typedef enum logic [1:0] {S_ISSUE = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_instr, r_opc;
    logic        r_valid, w_req, w_load;
    // Issue only when the slot is free or draining, so a response always finds it empty
    assign w_req  = rst && r_state == S_ISSUE && !i_redirect && (!r_valid || !i_stall);
    assign w_load = r_state == S_WAIT && i_imem_rvalid && !i_redirect;
    always_comb begin
        w_next = S_ISSUE;
        case (r_state)
            S_ISSUE: w_next = w_req ? S_WAIT : S_ISSUE;
            S_WAIT:  w_next = i_imem_rvalid ? S_ISSUE : (i_redirect ? S_DROP : S_WAIT);
            S_DROP:  w_next = i_imem_rvalid ? S_ISSUE : S_DROP;
            default: w_next = S_ISSUE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_ISSUE;
            r_pc    <= RESET_ADDR;
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_opc   <= RESET_ADDR;
        end else begin
            r_state <= w_next;
            if (i_redirect) begin
                r_pc    <= i_target & ~32'h3;
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
            end else if (w_load) begin
                r_pc    <= r_pc + 32'd4;
                r_valid <= 1'b1;
                r_instr <= i_imem_rdata;
                r_opc   <= r_pc;
            end else if (r_valid && !i_stall) begin
                r_valid <= 1'b0;
            end
        end
    end
    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_valid     = r_valid;
    assign o_instruct  = r_instr;
    assign o_pc        = r_opc;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage with a variable-latency memory model
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_target = 32'h0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        o_valid;
    logic [31:0] o_instruct;
    logic [31:0] o_pc;
    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    int          cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic        saw_valid;

    if_stage dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_redirect(i_redirect), .i_target(i_target),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata(i_imem_rdata), .o_valid(o_valid), .o_instruct(o_instruct), .o_pc(o_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !o_valid; i++) tick();
        check(tag, {31'b0, o_valid}, 32'd1);
    endtask

    // Memory answers lat cycles after sampling a request; reset cancels anything pending
    always @(negedge clk) begin
        i_imem_rvalid = 1'b0;
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = mem_word(paddr);
                    pend = 1'b0;
                end
            end
            if (o_imem_req) begin
                check("one_outstanding", {31'b0, pend}, 32'd0);
                pend  = 1'b1;
                cnt   = lat;
                paddr = o_imem_addr;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_instr", o_instruct, 32'h13);
        check("rst_pc", o_pc, 32'h0);
        check("rst_req", {31'b0, o_imem_req}, 32'd0);
        rst = 1'b1;
        #1;
        check("req0", {31'b0, o_imem_req}, 32'd1);
        check("addr0", o_imem_addr, 32'h0);
        tick();
        check("wait_noreq", {31'b0, o_imem_req}, 32'd0);
        tick();
        check("v0", {31'b0, o_valid}, 32'd1);
        check("pc0", o_pc, 32'h0);
        check("ins0", o_instruct, mem_word(32'h0));
        check("req4", {31'b0, o_imem_req}, 32'd1);
        check("addr4", o_imem_addr, 32'h4);
        tick();
        check("drained", {31'b0, o_valid}, 32'd0);
        tick();
        check("pc4", o_pc, 32'h4);
        check("ins4", o_instruct, mem_word(32'h4));
        i_stall = 1'b1;
        #1;
        check("stall_noreq", {31'b0, o_imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'b0, o_valid}, 32'd1);
            check("stall_pc", o_pc, 32'h4);
            check("stall_ins", o_instruct, mem_word(32'h4));
            check("stall_req", {31'b0, o_imem_req}, 32'd0);
        end
        i_stall = 1'b0;
        #1;
        check("rel_req", {31'b0, o_imem_req}, 32'd1);
        check("rel_addr", o_imem_addr, 32'h8);
        tick();
        tick();
        check("v8", {31'b0, o_valid}, 32'd1);
        check("pc8", o_pc, 32'h8);
        check("ins8", o_instruct, mem_word(32'h8));
        lat = 3;
        tick();
        i_redirect = 1'b1;
        i_target = 32'h103;
        #1;
        check("redir_noreq", {31'b0, o_imem_req}, 32'd0);
        tick();
        i_redirect = 1'b0;
        #1;
        check("drop_valid", {31'b0, o_valid}, 32'd0);
        check("drop_noreq", {31'b0, o_imem_req}, 32'd0);
        check("drop_addr", o_imem_addr, 32'h100);
        saw_valid = 1'b0;
        for (int i = 0; i < 20 && !o_imem_req; i++) begin
            tick();
            saw_valid |= o_valid;
        end
        check("stale_dropped", {31'b0, saw_valid}, 32'd0);
        check("req100", {31'b0, o_imem_req}, 32'd1);
        check("addr100", o_imem_addr, 32'h100);
        lat = 1;
        wait_valid("v100_timeout");
        check("pc100", o_pc, 32'h100);
        check("ins100", o_instruct, mem_word(32'h100));
        tick();
        check("resp_next", {31'b0, pend && cnt == 1}, 32'd1);
        i_redirect = 1'b1;
        i_target = 32'h200;
        tick();
        i_redirect = 1'b0;
        #1;
        check("coinc_valid", {31'b0, o_valid}, 32'd0);
        check("coinc_req", {31'b0, o_imem_req}, 32'd1);
        check("coinc_addr", o_imem_addr, 32'h200);
        tick();
        tick();
        check("pc200", o_pc, 32'h200);
        check("ins200", o_instruct, mem_word(32'h200));
        i_stall = 1'b1;
        #1;
        check("hold_noreq", {31'b0, o_imem_req}, 32'd0);
        tick();
        check("hold_valid", {31'b0, o_valid}, 32'd1);
        i_redirect = 1'b1;
        i_target = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        i_stall = 1'b0;
        #1;
        check("flush_valid", {31'b0, o_valid}, 32'd0);
        check("flush_instr", o_instruct, 32'h13);
        check("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("pcfc", o_pc, 32'hFFFF_FFFC);
        check("wrap_req", {31'b0, o_imem_req}, 32'd1);
        check("wrap_zero", o_imem_addr, 32'h0);
        lat = 3;
        tick();
        rst = 1'b0;
        tick();
        check("mid_valid", {31'b0, o_valid}, 32'd0);
        check("mid_req", {31'b0, o_imem_req}, 32'd0);
        check("mid_instr", o_instruct, 32'h13);
        rst = 1'b1;
        lat = 1;
        #1;
        check("mid_req1", {31'b0, o_imem_req}, 32'd1);
        check("mid_addr", o_imem_addr, 32'h0);
        tick();
        check("mid_wait", {31'b0, o_imem_req}, 32'd0);
        tick();
        check("mid_v", {31'b0, o_valid}, 32'd1);
        check("mid_pc", o_pc, 32'h0);
        check("mid_ins", o_instruct, mem_word(32'h0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
